// File: rtl/spi_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_rom_arbiter
//  Purpose  : Shares one SPI flash ROM between two requesters. Port 0 has
//             fixed priority over port 1. Each grant runs a complete READ
//             (03h) transaction: chip select, command byte, 24-bit address,
//             then a burst of 1..2**LEN_W bytes. Received bytes are
//             returned with the number of the port that owns them.
//  Revision : 1.0  initial release
// ============================================================================
module spi_rom_arbiter #(
    parameter int LEN_W  = 5,   // width of the burst length inputs; 0 means 2**LEN_W bytes
    parameter int CS_GAP = 2    // cycles spi_cs stays low between transactions (>= 1)
) (
    input  logic             clk,
    input  logic             reset,

    // SPI pads
    output logic             spi_cs,      // active high; the pad inverts it
    output logic             spi_sclk,
    output logic             spi_mosi,
    input  logic             spi_miso,

    // Port 0 (high priority)
    input  logic             req0,
    input  logic [23:0]      addr0,
    input  logic [LEN_W-1:0] len0,
    output logic             gnt0,

    // Port 1 (low priority)
    input  logic             req1,
    input  logic [23:0]      addr1,
    input  logic [LEN_W-1:0] len1,
    output logic             gnt1,

    // Read data return
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             rd_owner,
    output logic             done,
    output logic             busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The cycle counter must hold 32 command/address cycles plus the longest
    // burst of 8 * 2**LEN_W data cycles.
    localparam int c_CNT_W = $clog2(32 + 8 * (2 ** LEN_W));
    // The gap counter loads CS_GAP-1 and counts down to zero.
    localparam int c_GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    localparam logic [7:0] c_CMD_READ = 8'h03;

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_CMD  = 3'd1;
    localparam logic [2:0] c_ADDR = 3'd2;
    localparam logic [2:0] c_DATA = 3'd3;
    localparam logic [2:0] c_GAP  = 3'd4;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;       // cycle number within the transaction
    logic [31:0]        r_shift;     // remaining command/address bits, MSB next
    logic [LEN_W-1:0]   r_len;       // latched burst length of the winner
    logic [7:0]         r_byte;      // data bits assembled so far
    logic [c_GAP_W-1:0] r_gap;       // GAP cycles still to go after this one
    logic               r_miso_q;    // spi_miso sampled on rising SCLK

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic               w_arb_slot;  // a cycle in which a new grant may be made
    logic               w_start;     // grant issued at the coming edge
    logic               w_win;       // winning port number
    logic [23:0]        w_addr;
    logic [LEN_W-1:0]   w_len;
    logic [LEN_W:0]     w_len_eff;   // burst length with 0 expanded to 2**LEN_W
    logic [c_CNT_W-1:0] w_last_cnt;  // value of r_cnt in the final data cycle

    // Arbitration is allowed in IDLE and in the last GAP cycle, so that a
    // held request restarts exactly CS_GAP cycles after chip select drops.
    assign w_arb_slot = (r_state == c_IDLE) ||
                        ((r_state == c_GAP) && (r_gap == '0));
    assign w_start    = w_arb_slot && (req0 || req1);

    // Fixed priority: port 1 wins only when port 0 is not requesting.
    assign w_win  = ~req0;
    assign w_addr = w_win ? addr1 : addr0;
    assign w_len  = w_win ? len1  : len0;

    assign w_len_eff  = (r_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, r_len};
    // Last data cycle is 32 + 8*N - 1.
    assign w_last_cnt = c_CNT_W'(31) + c_CNT_W'({w_len_eff, 3'b000});

    // SCLK is the inverted system clock, running continuously.
    assign spi_sclk = ~clk;

    assign busy = (r_state != c_IDLE);

    // ------------------------------------------------------------------------
    // Capture flash data on rising SCLK, half a cycle after it was launched.
    // ------------------------------------------------------------------------
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_miso_q <= 1'b0;
        end else begin
            r_miso_q <= spi_miso;
        end
    end

    // ------------------------------------------------------------------------
    // Transaction sequencer: arbitration, command/address shift-out,
    // data assembly and chip-select gap.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_len    <= '0;
            r_byte   <= '0;
            r_gap    <= '0;
            spi_cs   <= 1'b0;
            spi_mosi <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_owner <= 1'b0;
            done     <= 1'b0;
        end else begin
            // Strobes are single-cycle unless set again below.
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rd_valid <= 1'b0;
            done     <= 1'b0;

            if (w_start) begin
                // Cycle 0 begins: raise CS, drive CMD[7], latch the winner's
                // request. The rest of the command and the address wait in
                // r_shift, so later changes on addrN/lenN have no effect.
                r_state  <= c_CMD;
                r_cnt    <= '0;
                spi_cs   <= 1'b1;
                spi_mosi <= c_CMD_READ[7];
                r_shift  <= {c_CMD_READ[6:0], w_addr, 1'b0};
                r_len    <= w_len;
                rd_owner <= w_win;
                gnt0     <= ~w_win;
                gnt1     <= w_win;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        r_state <= c_IDLE;
                    end

                    c_CMD: begin
                        spi_mosi <= r_shift[31];
                        r_shift  <= {r_shift[30:0], 1'b0};
                        r_cnt    <= r_cnt + c_CNT_W'(1);
                        if (r_cnt == c_CNT_W'(7)) begin
                            r_state <= c_ADDR;
                        end
                    end

                    c_ADDR: begin
                        // After the 31st shift r_shift is empty, so MOSI
                        // drops to 0 as the burst begins.
                        spi_mosi <= r_shift[31];
                        r_shift  <= {r_shift[30:0], 1'b0};
                        r_cnt    <= r_cnt + c_CNT_W'(1);
                        if (r_cnt == c_CNT_W'(31)) begin
                            r_state <= c_DATA;
                        end
                    end

                    c_DATA: begin
                        spi_mosi <= 1'b0;
                        r_byte   <= {r_byte[6:0], r_miso_q};
                        // Data starts at cycle 32, a multiple of 8, so the
                        // low three counter bits give the bit position.
                        if (r_cnt[2:0] == 3'd7) begin
                            rd_data  <= {r_byte[6:0], r_miso_q};
                            rd_valid <= 1'b1;
                        end
                        if (r_cnt == w_last_cnt) begin
                            spi_cs  <= 1'b0;
                            done    <= 1'b1;
                            r_gap   <= c_GAP_W'(CS_GAP - 1);
                            r_state <= c_GAP;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end

                    c_GAP: begin
                        // A request in the final GAP cycle is taken by
                        // w_start above; otherwise fall back to IDLE.
                        if (r_gap == '0) begin
                            r_state <= c_IDLE;
                        end else begin
                            r_gap <= r_gap - c_GAP_W'(1);
                        end
                    end

                    default: begin
                        r_state <= c_IDLE;
                        spi_cs  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_rom_arbiter
//  Purpose  : Directed self-checking bench for spi_rom_arbiter with a simple
//             flash data model driven from hand-chosen byte tables.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_rom_arbiter;

    localparam int LEN_W  = 5;
    localparam int CS_GAP = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_cs, spi_sclk, spi_mosi, spi_miso;
    logic        req0, req1, gnt0, gnt1;
    logic [23:0] addr0, addr1;
    logic [LEN_W-1:0] len0, len1;
    logic [7:0]  rd_data;
    logic        rd_valid, rd_owner, done, busy;

    int n_tot = 0;
    int n_bad = 0;
    int w;
    logic [7:0] mem [0:31];   // bytes the flash returns for the current burst

    spi_rom_arbiter #(.LEN_W(LEN_W), .CS_GAP(CS_GAP)) dut (
        .clk      (clk),
        .reset    (reset),
        .spi_cs   (spi_cs),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .req0     (req0),
        .addr0    (addr0),
        .len0     (len0),
        .gnt0     (gnt0),
        .req1     (req1),
        .addr1    (addr1),
        .len1     (len1),
        .gnt1     (gnt1),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_owner (rd_owner),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until spi_cs reads high; returns the number of steps taken.
    task automatic wait_cs(output int cnt);
        cnt = 0;
        while (spi_cs !== 1'b1 && cnt < 16) begin
            step();
            cnt++;
        end
    endtask

    // Called in cycle 0 of a transaction; returns in the cycle after the last
    // GAP cycle. Checks every cycle: {cs, mosi, gnt0, gnt1, rd_valid, done, busy}.
    task automatic run_txn(input int n, input logic own, input logic [31:0] ca,
                           input bit drop, input bit chg);
        int last;
        int j;
        logic [6:0] exp_v;
        logic [6:0] got_v;
        last = 32 + 8 * n;
        for (int c = 0; c < last + CS_GAP; c++) begin
            if (c >= 32 && c < last) begin
                j = c - 32;
                spi_miso = mem[j / 8][7 - (j % 8)];
            end else begin
                spi_miso = 1'b0;
            end
            exp_v = {c < last,
                     (c < 32) ? ca[31 - c] : 1'b0,
                     (c == 0) && !own,
                     (c == 0) && own,
                     (c >= 40) && (c <= last) && (c % 8 == 0),
                     c == last,
                     1'b1};
            got_v = {spi_cs, spi_mosi, gnt0, gnt1, rd_valid, done, busy};
            chk($sformatf("cyc%0d", c), {25'd0, got_v}, {25'd0, exp_v});
            if ((c >= 40) && (c <= last) && (c % 8 == 0)) begin
                chk($sformatf("rd_data%0d", (c - 40) / 8), {24'd0, rd_data}, {24'd0, mem[(c - 40) / 8]});
                chk("rd_owner", {31'd0, rd_owner}, {31'd0, own});
            end
            if (c == 0 && drop) begin
                if (own) req1 = 1'b0;
                else     req0 = 1'b0;
            end
            if (c == 1 && chg) begin
                addr0 = 24'hFFFFFF;
                len0  = 5'd5;
            end
            step();
        end
    endtask

    initial begin
        reset = 1'b1; spi_miso = 1'b0;
        req0 = 1'b0; addr0 = '0; len0 = '0;
        req1 = 1'b0; addr1 = '0; len1 = '0;
        step();
        step();
        chk("rst_outs", {25'd0, spi_cs, spi_mosi, gnt0, gnt1, rd_valid, done, busy}, 32'd0);
        chk("rst_data", {23'd0, rd_owner, rd_data}, 32'd0);

        // Single read of two bytes from port 0.
        reset = 1'b0;
        req0 = 1'b1; addr0 = 24'h000130; len0 = 5'd2;
        mem[0] = 8'hA5; mem[1] = 8'h3C;
        wait_cs(w);
        chk("t1_lat", w, 1);
        run_txn(2, 1'b0, 32'h03000130, 1'b1, 1'b0);
        chk("t1_idle", {30'd0, spi_cs, busy}, 32'd0);

        // Simultaneous requests: port 0 first, port 1 right after the gap.
        req0 = 1'b1; addr0 = 24'h00A000; len0 = 5'd1;
        req1 = 1'b1; addr1 = 24'h0B0000; len1 = 5'd1;
        mem[0] = 8'h5A;
        wait_cs(w);
        chk("t2_lat", w, 1);
        run_txn(1, 1'b0, 32'h0300A000, 1'b1, 1'b0);
        mem[0] = 8'hC3;
        run_txn(1, 1'b1, 32'h030B0000, 1'b1, 1'b0);
        chk("t2_idle", {30'd0, spi_cs, busy}, 32'd0);

        // Length 0 on port 1 means a 32-byte burst.
        req1 = 1'b1; addr1 = 24'h7FFFF0; len1 = 5'd0;
        for (int k = 0; k < 32; k++) mem[k] = 8'(k * 37 + 1);
        wait_cs(w);
        chk("t3_lat", w, 1);
        run_txn(32, 1'b1, 32'h037FFFF0, 1'b1, 1'b0);
        chk("t3_idle", {30'd0, spi_cs, busy}, 32'd0);

        // Back-to-back: req0 held high, a new transaction every 42 cycles.
        req0 = 1'b1; addr0 = 24'h000200; len0 = 5'd1;
        mem[0] = 8'h81;
        wait_cs(w);
        chk("t4_lat", w, 1);
        run_txn(1, 1'b0, 32'h03000200, 1'b0, 1'b0);
        run_txn(1, 1'b0, 32'h03000200, 1'b0, 1'b0);
        run_txn(1, 1'b0, 32'h03000200, 1'b1, 1'b0);
        chk("t4_idle", {30'd0, spi_cs, busy}, 32'd0);

        // Reset in cycle 36 of a 4-byte read, then port 1 takes over.
        req0 = 1'b1; addr0 = 24'h010000; len0 = 5'd4;
        wait_cs(w);
        chk("t5_lat", w, 1);
        for (int c = 0; c < 36; c++) begin
            if (c == 0) req0 = 1'b0;
            spi_miso = 1'($urandom_range(0, 1));
            step();
        end
        chk("t5_c36", {30'd0, spi_cs, busy}, 32'd3);
        reset = 1'b1;
        req1 = 1'b1; addr1 = 24'h000040; len1 = 5'd1;
        #1;
        chk("t5_async", {25'd0, spi_cs, spi_mosi, gnt0, gnt1, rd_valid, done, busy}, 32'd0);
        step();
        chk("t5_hold", {25'd0, spi_cs, spi_mosi, gnt0, gnt1, rd_valid, done, busy}, 32'd0);
        reset = 1'b0;
        mem[0] = 8'h99;
        wait_cs(w);
        chk("t5_relat", w, 1);
        run_txn(1, 1'b1, 32'h03000040, 1'b1, 1'b0);
        chk("t5_idle", {30'd0, spi_cs, busy}, 32'd0);

        // Changing addr0/len0 after the grant must not affect the transaction.
        req0 = 1'b1; addr0 = 24'h123456; len0 = 5'd2;
        mem[0] = 8'h0F; mem[1] = 8'hF0;
        wait_cs(w);
        chk("t6_lat", w, 1);
        run_txn(2, 1'b0, 32'h03123456, 1'b1, 1'b1);
        chk("t6_idle", {30'd0, spi_cs, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
